multicycle_control: RTL

Main control state machine for the multicycle MIPS-subset processor. It sequences the shared 32-bit ALU (selects AND 000, ADD 001, OR 010, SUB 011, SLT 100, NOR 101) and the PC, instruction-register, memory and register-file enables over 3–5 cycles per instruction. The ALU handles PC increment, branch-target computation, address generation and execution. The block sits between the instruction register (opcode/funct) and the datapath multiplexers, and consumes the ALU zero flag for beq.

---
 rtl/multicycle_control.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS-subset datapath: sequences the ALU,
// PC, IR, memory and register-file controls over 3-5 cycles per instruction.
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero_flag,
  output logic       pc_write,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       zero_ext,
  output logic [2:0] alu_sel,
  output logic [1:0] pc_source,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    R_EXEC    = 4'd6,
    R_WB      = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9,
    I_EXEC    = 4'd10,
    I_WB      = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;
  localparam logic [2:0] ALU_NOR = 3'b101;

  state_t     cur_state;
  state_t     nxt_state;
  logic       funct_ok;
  logic [2:0] funct_sel;
  logic       decode_bad;

  always_comb begin
    funct_ok  = 1'b1;
    funct_sel = ALU_AND;
    case (funct)
      6'b100000: funct_sel = ALU_ADD;
      6'b100010: funct_sel = ALU_SUB;
      6'b100100: funct_sel = ALU_AND;
      6'b100101: funct_sel = ALU_OR;
      6'b101010: funct_sel = ALU_SLT;
      6'b100111: funct_sel = ALU_NOR;
      default:   funct_ok  = 1'b0;
    endcase
  end

  always_comb begin
    case (opcode)
      OP_RTYPE:                    decode_bad = !funct_ok;
      OP_LW, OP_SW, OP_BEQ, OP_J,
      OP_ADDI, OP_ANDI, OP_ORI:    decode_bad = 1'b0;
      default:                     decode_bad = 1'b1;
    endcase
  end

  always_comb begin
    nxt_state = FETCH;
    case (cur_state)
      FETCH: nxt_state = DECODE;
      DECODE: begin
        if (decode_bad) nxt_state = FETCH;
        else begin
          case (opcode)
            OP_RTYPE:                 nxt_state = R_EXEC;
            OP_LW, OP_SW:             nxt_state = MEM_ADDR;
            OP_BEQ:                   nxt_state = BRANCH;
            OP_J:                     nxt_state = JUMP;
            OP_ADDI, OP_ANDI, OP_ORI: nxt_state = I_EXEC;
            default:                  nxt_state = FETCH;
          endcase
        end
      end
      MEM_ADDR: begin
        if (opcode == OP_LW)      nxt_state = MEM_READ;
        else if (opcode == OP_SW) nxt_state = MEM_WRITE;
        else                      nxt_state = FETCH;
      end
      MEM_READ: nxt_state = MEM_WB;
      R_EXEC:   nxt_state = R_WB;
      I_EXEC:   nxt_state = I_WB;
      default:  nxt_state = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) cur_state <= FETCH;
    else       cur_state <= nxt_state;
  end

  // Reset gates every output combinationally so no strobe leaks in the reset cycle.
  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    zero_ext   = 1'b0;
    alu_sel    = ALU_AND;
    pc_source  = 2'b00;
    instr_done = 1'b0;
    illegal    = 1'b0;
    state      = '0;
    if (!reset) begin
      state = cur_state;
      case (cur_state)
        FETCH: begin
          mem_read  = 1'b1;
          ir_write  = 1'b1;
          alu_src_b = 2'b01;
          alu_sel   = ALU_ADD;
          pc_write  = 1'b1;
        end
        DECODE: begin
          alu_src_b  = 2'b11;
          alu_sel    = ALU_ADD;
          illegal    = decode_bad;
          instr_done = decode_bad;
        end
        MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          alu_sel   = ALU_ADD;
        end
        MEM_READ: begin
          mem_read = 1'b1;
          iord     = 1'b1;
        end
        MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
        end
        MEM_WRITE: begin
          mem_write  = 1'b1;
          iord       = 1'b1;
          instr_done = 1'b1;
        end
        R_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b00;
          alu_sel   = funct_sel;
        end
        R_WB: begin
          reg_write  = 1'b1;
          reg_dst    = 1'b1;
          instr_done = 1'b1;
        end
        BRANCH: begin
          alu_src_a  = 1'b1;
          alu_src_b  = 2'b00;
          alu_sel    = ALU_SUB;
          pc_source  = 2'b01;
          pc_write   = zero_flag;
          instr_done = 1'b1;
        end
        JUMP: begin
          pc_source  = 2'b10;
          pc_write   = 1'b1;
          instr_done = 1'b1;
        end
        I_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          case (opcode)
            OP_ADDI: alu_sel = ALU_ADD;
            OP_ANDI: begin
              alu_sel  = ALU_AND;
              zero_ext = 1'b1;
            end
            OP_ORI: begin
              alu_sel  = ALU_OR;
              zero_ext = 1'b1;
            end
            default: alu_sel = ALU_AND;
          endcase
        end
        I_WB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        default: state = cur_state;
      endcase
    end
  end

endmodule
